// File: rtl/clock_enable_bank.sv
// Bank of independent runtime-programmable clock dividers. Each channel gives a
// one-cycle tick (clock enable) and a 50 % square wave derived from i_Clk.
module clock_enable_bank #(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = 23,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 23'd2200000,
  parameter int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Enable,
  input  logic              i_Sync,
  input  logic              i_Load,
  input  logic [CH_W-1:0]   i_Load_Ch,
  input  logic [WIDTH-1:0]  i_Load_Div,
  output logic [NUM_CH-1:0] o_Tick,
  output logic [NUM_CH-1:0] o_Wave,
  output logic [NUM_CH-1:0] o_Pending
);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shd;
    logic             pend;
    logic             tick;
    logic             wave;
  } ch_t;

  localparam ch_t CH_RESET = '{
    cnt:  '0,
    div:  DEFAULT_DIV,
    shd:  DEFAULT_DIV,
    pend: 1'b0,
    tick: 1'b0,
    wave: 1'b0
  };

  ch_t ch_q [NUM_CH];
  ch_t ch_d [NUM_CH];

  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] load_hit;
  logic [NUM_CH-1:0] commit;

  // Wrap on >= so a divisor committed below a held count (stopped channel)
  // still ends the period instead of running the counter round 2^WIDTH.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wrap[c]     = (ch_q[c].cnt >= ch_q[c].div);
      load_hit[c] = i_Load && (i_Load_Ch == CH_W'(c));
      commit[c]   = ch_q[c].pend && (i_Sync || !i_Enable[c] || wrap[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      // NOTE: every field starts from its held value, so no path can infer a latch.
      ch_d[c]      = ch_q[c];
      ch_d[c].tick = 1'b0;

      if (i_Sync) begin
        ch_d[c].cnt  = '0;
        ch_d[c].wave = 1'b0;
      end else if (i_Enable[c]) begin
        if (wrap[c]) begin
          ch_d[c].cnt  = '0;
          ch_d[c].tick = 1'b1;
          ch_d[c].wave = ~ch_q[c].wave;
        end else begin
          ch_d[c].cnt = ch_q[c].cnt + WIDTH'(1);
        end
      end

      if (commit[c]) begin
        ch_d[c].div  = ch_q[c].shd;
        ch_d[c].pend = 1'b0;
      end

      // A load landing with a commit re-arms pend: the old shadow commits now,
      // the new value waits for the following boundary.
      if (load_hit[c]) begin
        ch_d[c].shd  = i_Load_Div;
        ch_d[c].pend = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= CH_RESET;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // NOTE: non-blocking so every channel samples the pre-edge state.
        ch_q[c] <= ch_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      o_Tick[c]    = ch_q[c].tick;
      o_Wave[c]    = ch_q[c].wave;
      o_Pending[c] = ch_q[c].pend;
    end
  end

endmodule

// File: tb/tb_clock_enable_bank.sv
// Self-checking bench for clock_enable_bank: directed test-plan scenarios, then
// randomized traffic compared every cycle with a behavioural model.
module tb_clock_enable_bank;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DEF = 3;

  logic           i_Clk;
  logic           i_Rst_L;
  logic [NCH-1:0] i_Enable;
  logic           i_Sync;
  logic           i_Load;
  logic [1:0]     i_Load_Ch;
  logic [W-1:0]   i_Load_Div;
  logic [NCH-1:0] o_Tick;
  logic [NCH-1:0] o_Wave;
  logic [NCH-1:0] o_Pending;

  clock_enable_bank #(
    .NUM_CH     (NCH),
    .WIDTH      (W),
    .DEFAULT_DIV(8'd3)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Enable  (i_Enable),
    .i_Sync    (i_Sync),
    .i_Load    (i_Load),
    .i_Load_Ch (i_Load_Ch),
    .i_Load_Div(i_Load_Div),
    .o_Tick    (o_Tick),
    .o_Wave    (o_Wave),
    .o_Pending (o_Pending)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: each channel is a position within its period of div+1 steps.
  int m_pos  [NCH];
  int m_div  [NCH];
  int m_shd  [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  bit m_wave [NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0;  m_div[c] = DEF;  m_shd[c] = DEF;
      m_pend[c] = 0; m_tick[c] = 0;   m_wave[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit sync, input bit load, input int ch,
                                     input int dv, input bit [NCH-1:0] en);
    for (int c = 0; c < NCH; c++) begin
      bit boundary;
      m_tick[c] = 0;
      boundary  = 0;
      if (sync) begin
        m_pos[c]  = 0;
        m_wave[c] = 0;
        boundary  = 1;
      end else if (!en[c]) begin
        boundary = 1;
      end else if (m_pos[c] + 1 > m_div[c]) begin
        m_pos[c]  = 0;
        m_tick[c] = 1;
        m_wave[c] = !m_wave[c];
        boundary  = 1;
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
      if (boundary && m_pend[c]) begin
        m_div[c]  = m_shd[c];
        m_pend[c] = 0;
      end
      if (load && ch == c) begin
        m_shd[c]  = dv;
        m_pend[c] = 1;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] pack(input bit which);
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = which ? m_wave[c] : m_tick[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] pack_pend();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  task automatic step(input bit sync, input bit load, input int ch, input int dv,
                      input bit [NCH-1:0] en);
    i_Sync     = sync;
    i_Load     = load;
    i_Load_Ch  = 2'(ch);
    i_Load_Div = W'(dv);
    i_Enable   = en;
    @(posedge i_Clk);
    model_step(sync, load, ch, dv, en);
    @(negedge i_Clk);
    check("tick", 32'(o_Tick), 32'(pack(0)));
    check("wave", 32'(o_Wave), 32'(pack(1)));
    check("pending", 32'(o_Pending), 32'(pack_pend()));
  endtask

  task automatic idle(input int n, input bit [NCH-1:0] en);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, en);
  endtask

  initial begin
    i_Rst_L    = 1'b0;
    i_Enable   = '1;
    i_Sync     = 1'b0;
    i_Load     = 1'b0;
    i_Load_Ch  = '0;
    i_Load_Div = '0;
    model_reset();
    repeat (3) @(negedge i_Clk);
    check("reset_tick", 32'(o_Tick), 0);
    check("reset_wave", 32'(o_Wave), 0);
    check("reset_pend", 32'(o_Pending), 0);
    i_Rst_L = 1'b1;

    // Edges 1..8: default divisor 3, load ch0 div=1 at edge 2.
    step(0, 0, 0, 0, '1);
    step(0, 1, 0, 1, '1);
    check("pend_after_load", 32'(o_Pending), 32'h1);
    step(0, 0, 0, 0, '1);
    check("pend_held", 32'(o_Pending), 32'h1);
    step(0, 0, 0, 0, '1);
    check("first_tick_e4", 32'(o_Tick), 32'h7);
    check("wave_rise_e4", 32'(o_Wave), 32'h7);
    check("pend_clear_e4", 32'(o_Pending), 32'h0);
    idle(2, '1);
    check("ch0_fast_e6", 32'(o_Tick), 32'h1);
    idle(2, '1);
    check("tick_e8", 32'(o_Tick), 32'h7);
    check("wave_fall_e8", 32'(o_Wave[2:1]), 32'h0);

    // Edge 12: load ch1 div=0 coincident with its wrap.
    idle(3, '1);
    step(0, 1, 1, 0, '1);
    check("coincident_tick", 32'(o_Tick[1]), 1);
    check("coincident_pend", 32'(o_Pending[1]), 1);
    idle(3, '1);
    check("old_period_e15", 32'(o_Tick[1]), 0);
    idle(1, '1);
    check("wrap_e16", 32'(o_Tick[1]), 1);
    idle(2, '1);
    check("div0_steady", 32'(o_Tick[1]), 1);

    // Edges 19..23: ch2 (cnt=2) disabled for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 3'b011);
      check("gated_no_tick", 32'(o_Tick[2]), 0);
      check("gated_wave_hold", 32'(o_Wave[2]), 0);
    end
    step(0, 0, 0, 0, '1);
    check("reenable_e24", 32'(o_Tick[2]), 0);
    step(0, 0, 0, 0, '1);
    check("reenable_tick", 32'(o_Tick[2]), 1);

    // Sync alignment with ch0/ch1 restored to div=3.
    step(0, 1, 0, 3, '1);
    step(0, 1, 1, 3, '1);
    step(1, 0, 0, 0, '1);
    check("sync_wave", 32'(o_Wave), 0);
    check("sync_pend", 32'(o_Pending), 0);
    idle(3, '1);
    check("sync_quiet", 32'(o_Tick), 0);
    idle(1, '1);
    check("sync_aligned", 32'(o_Tick), 32'h7);
    idle(4, '1);
    check("sync_aligned2", 32'(o_Tick), 32'h7);

    // Invalid channel, then reset with a load pending.
    step(0, 1, 3, 0, '1);
    check("invalid_ch", 32'(o_Pending), 0);
    step(0, 1, 0, 5, '1);
    check("pend_before_rst", 32'(o_Pending), 32'h1);
    #2 i_Rst_L = 1'b0;
    #1;
    check("async_tick", 32'(o_Tick), 0);
    check("async_wave", 32'(o_Wave), 0);
    check("async_pend", 32'(o_Pending), 0);
    model_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    idle(4, '1);
    check("default_restored", 32'(o_Tick), 32'h7);

    // Randomized traffic with occasional syncs, max divisor and async resets.
    for (int i = 0; i < 3000; i++) begin
      bit          s, l;
      int          ch, dv;
      bit [NCH-1:0] en;
      s  = ($urandom_range(63) == 0);
      l  = ($urandom_range(5) == 0);
      ch = $urandom_range(3);
      dv = ($urandom_range(99) == 0) ? 255 : $urandom_range(6);
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(7) != 0);
      step(s, l, ch, dv, en);
      if (i % 700 == 699) begin
        #2 i_Rst_L = 1'b0;
        #1 check("rand_async", 32'({o_Tick, o_Wave, o_Pending}), 0);
        model_reset();
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
      end
    end

    // Maximum divisor: period of 2^WIDTH cycles on ch0.
    step(0, 1, 0, 255, '1);
    step(1, 0, 0, 0, '1);
    idle(255, '1);
    check("max_div_quiet", 32'(o_Tick[0]), 0);
    idle(1, '1);
    check("max_div_tick", 32'(o_Tick[0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
